// File: rtl/dice_roll.sv
// dice_roll: roll-a-die stage that feeds the choose/score stage of the dice game.
//
// The controller arms the block with a one-cycle pulse at the start of a turn.
// A fresh press of the roll button (rising edge seen while armed) starts a spin.
// The spin lasts SPIN_CYCLES cycles. It then latches the first valid value 1..6
// taken from a free-running 8-bit maximal-length LFSR and announces it with a
// one-cycle pulse.
//
// Optional feature (macro DICE_ROLL_FORCE_EN): adds force_en/force_num. When
// force_num is 1..6 and force_en is high on the latch cycle, force_num is
// latched instead of the LFSR candidate.
//
// Ports:
//   clk       in   system clock, everything on posedge
//   rst_n     in   synchronous active-low reset
//   pulse_i   in   one-cycle start-of-turn pulse from the controller
//   roll      in   roll button level (already synchronised)
//   force_en  in   (DICE_ROLL_FORCE_EN only) force the latched value
//   force_num in   (DICE_ROLL_FORCE_EN only) value to force, 1..6
//   num       out  latched die value 1..6, 0 until the first roll
//   pulse_o   out  one-cycle pulse: num is valid and final
//   disp      out  animated value for the display, equals num outside SPIN
//   busy      out  high in ARMED, SPIN and DONE
//   state_o   out  FSM state (0 IDLE, 1 ARMED, 2 SPIN, 3 DONE), for observation
//   lfsr_o    out  current LFSR contents, for observation
//
// Handshake: pulse_o is a valid-only strobe with no ready. num stays valid
// from the pulse_o cycle until the next latch. The controller must not send
// another pulse_i before it has seen pulse_o.
module dice_roll #(
  parameter int unsigned SPIN_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse_i,
  input  logic       roll,
`ifdef DICE_ROLL_FORCE_EN
  input  logic       force_en,
  input  logic [2:0] force_num,
`endif
  output logic [2:0] num,
  output logic       pulse_o,
  output logic [2:0] disp,
  output logic       busy,
  output logic [1:0] state_o,
  output logic [7:0] lfsr_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SPIN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] CNT_LOAD = 16'(SPIN_CYCLES - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  lfsr_d;
  logic        roll_q;
  logic [2:0]  num_q;
  logic [2:0]  disp_q;

  logic [2:0]  cand;
  logic        cand_ok;
  logic        rise;
  logic        latch_ok;
  logic [2:0]  latch_val;

  always_comb begin
    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cand      = lfsr_q[2:0];
    // 0 and 7 are rejected outright; remapping them would skew the faces.
    cand_ok   = (cand != 3'd0) && (cand != 3'd7);
    rise      = roll & ~roll_q;
    latch_val = cand;
    latch_ok  = cand_ok;
`ifdef DICE_ROLL_FORCE_EN
    if (force_en && (force_num != 3'd0) && (force_num != 3'd7)) begin
      latch_val = force_num;
      latch_ok  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      lfsr_q  <= SEED;
      roll_q  <= 1'b0;
      num_q   <= 3'd0;
      disp_q  <= 3'd0;
    end else begin
      lfsr_q <= lfsr_d;
      // roll_q tracks the button in every state. A press still held on
      // entry to ARMED therefore shows no edge and has to be re-pressed.
      roll_q <= roll;
      case (state_q)
        IDLE: begin
          if (pulse_i) state_q <= ARMED;
        end
        ARMED: begin
          if (rise) begin
            state_q <= SPIN;
            cnt_q   <= CNT_LOAD;
          end
        end
        SPIN: begin
          if (cand_ok) disp_q <= cand;
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (latch_ok) begin
            num_q   <= latch_val;
            disp_q  <= latch_val;
            state_q <= DONE;
          end
          // Otherwise cnt stays 0 and the next candidate is tried.
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign num     = num_q;
  assign disp    = disp_q;
  assign pulse_o = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign state_o = state_q;
  assign lfsr_o  = lfsr_q;

endmodule
